// File: rtl/bus_addr_demux_pkg.sv
// Shared types and defaults for the address-decoded request demux.
// Device ids carry one extra code above the last device that marks locally answered unmapped requests.
package bus_addr_demux_pkg;

    localparam int unsigned MAX_NUM_DEV = 8;
    localparam int unsigned DEV_ID_W    = $clog2(MAX_NUM_DEV + 1);
    typedef logic [DEV_ID_W-1:0] dev_id_t;

    localparam int unsigned DEF_NUM_DEV = 2;
    localparam dev_id_t     ERR_ID      = dev_id_t'(DEF_NUM_DEV);

    localparam logic [DEF_NUM_DEV-1:0][31:0] DEF_DEV_BASE = {32'h0001_0000, 32'h0000_0000};
    localparam logic [DEF_NUM_DEV-1:0][31:0] DEF_DEV_MASK = {32'hFFFF_0000, 32'hFFFF_0000};

    localparam int unsigned WDOG_W = 16;
    localparam int unsigned DROP_W = 4;

    // The error id always sits just above the highest device index.
    function automatic dev_id_t err_id(input int unsigned num_dev);
        return dev_id_t'(num_dev);
    endfunction

endpackage

// File: rtl/bus_addr_demux_fifo.sv
// In-order FIFO of target ids for outstanding host transactions.
// Latency: push visible at head/tail the cycle after the push edge.
// Backpressure: none internally; the caller never pushes while full.
module bus_addr_demux_fifo
    import bus_addr_demux_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  dev_id_t          push_id,
    input  logic             pop,
    output dev_id_t          head_id,
    output dev_id_t          tail_id,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    dev_id_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign tail_ptr = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
    assign head_id  = mem[rd_ptr];
    assign tail_id  = mem[tail_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_addr_demux.sv
// Address-decoded fan-out of one req/gnt/rvalid host port to NUM_DEV devices, with in-order response steering.
// Latency: request, grant and response paths are combinational; unmapped requests answer one cycle after grant.
// Backpressure: gnt_o held low while the tracker is full or a new target waits for older responses to drain.
// Optional: BUS_ADDR_DEMUX_TIMEOUT_EN adds a response watchdog with per-device late-response drop counters.
module bus_addr_demux
    import bus_addr_demux_pkg::*;
#(
    parameter int unsigned                          NUM_DEV         = 2,
    parameter int unsigned                          ADDR_WIDTH      = 32,
    parameter int unsigned                          DATA_WIDTH      = 32,
    parameter int unsigned                          MAX_OUTSTANDING = 2,
    parameter logic [NUM_DEV-1:0][ADDR_WIDTH-1:0]   DEV_BASE        = DEF_DEV_BASE,
    parameter logic [NUM_DEV-1:0][ADDR_WIDTH-1:0]   DEV_MASK        = DEF_DEV_MASK,
    parameter int unsigned                          TIMEOUT_CYCLES  = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_i,
    output logic                                  gnt_o,
    input  logic                                  we_i,
    input  logic [DATA_WIDTH/8-1:0]               be_i,
    input  logic [ADDR_WIDTH-1:0]                 addr_i,
    input  logic [DATA_WIDTH-1:0]                 wdata_i,
    output logic                                  rvalid_o,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  err_o,
    output logic [NUM_DEV-1:0]                    dev_req_o,
    input  logic [NUM_DEV-1:0]                    dev_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 dev_addr_o,
    output logic                                  dev_we_o,
    output logic [DATA_WIDTH/8-1:0]               dev_be_o,
    output logic [DATA_WIDTH-1:0]                 dev_wdata_o,
    input  logic [NUM_DEV-1:0]                    dev_rvalid_i,
    input  logic [NUM_DEV-1:0][DATA_WIDTH-1:0]    dev_rdata_i,
    input  logic [NUM_DEV-1:0]                    dev_err_i,
    output logic [NUM_DEV-1:0]                    dev_sel_o
);

    localparam dev_id_t     ERR_TGT = err_id(NUM_DEV);
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

    dev_id_t            target;
    dev_id_t            head_id;
    dev_id_t            tail_id;
    logic [CNT_W-1:0]   count;
    logic [NUM_DEV-1:0] tgt_oh;
    logic [NUM_DEV-1:0] head_oh;
    logic [NUM_DEV-1:0] dev_rv;
    logic               nonempty;
    logic               head_is_err;
    logic               head_rv;
    logic               timeout;
    logic               issue;
    logic               push;
    logic               pop;

    // Lowest matching index wins, so scan from the top down and let later hits override.
    always_comb begin
        target  = ERR_TGT;
        tgt_oh  = '0;
        head_oh = '0;
        for (int i = int'(NUM_DEV) - 1; i >= 0; i--) begin
            if ((addr_i & DEV_MASK[i]) == DEV_BASE[i]) begin
                target = dev_id_t'(i);
            end
        end
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            tgt_oh[i]  = (target == dev_id_t'(i));
            head_oh[i] = nonempty && (head_id == dev_id_t'(i));
        end
    end

    assign nonempty    = (count != '0);
    assign head_is_err = nonempty && (head_id == ERR_TGT);

    // Only one target may be in flight at a time, which keeps responses in order without tagging.
    assign issue     = rst_ni && req_i && (count < CNT_W'(MAX_OUTSTANDING))
                       && ((count == '0) || (target == tail_id));
    assign dev_req_o = issue ? tgt_oh : '0;
    assign gnt_o     = issue && ((target == ERR_TGT) || |(dev_gnt_i & tgt_oh));
    assign push      = gnt_o;

    assign dev_addr_o  = addr_i;
    assign dev_we_o    = we_i;
    assign dev_be_o    = be_i;
    assign dev_wdata_o = wdata_i;

`ifdef BUS_ADDR_DEMUX_TIMEOUT_EN
    logic [WDOG_W-1:0]  wdog;
    logic [DROP_W-1:0]  drop_cnt [NUM_DEV];
    logic [NUM_DEV-1:0] swallow;

    // A late response to a timed-out transaction is consumed here and never reaches the host.
    always_comb begin
        swallow = '0;
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            swallow[i] = dev_rvalid_i[i] && (drop_cnt[i] != '0);
        end
    end

    assign dev_rv  = dev_rvalid_i & ~swallow;
    assign timeout = nonempty && !head_is_err && !(|(dev_rv & head_oh))
                     && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog <= '0;
            for (int i = 0; i < int'(NUM_DEV); i++) begin
                drop_cnt[i] <= '0;
            end
        end else begin
            if (!nonempty || pop) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end
            for (int i = 0; i < int'(NUM_DEV); i++) begin
                case ({timeout && head_oh[i], swallow[i]})
                    2'b10:   drop_cnt[i] <= drop_cnt[i] + 1'b1;
                    2'b01:   drop_cnt[i] <= drop_cnt[i] - 1'b1;
                    default: drop_cnt[i] <= drop_cnt[i];
                endcase
            end
        end
    end
`else
    assign dev_rv  = dev_rvalid_i;
    assign timeout = 1'b0;
`endif

    assign head_rv   = |(dev_rv & head_oh);
    assign rvalid_o  = rst_ni && (head_is_err || head_rv || timeout);
    assign err_o     = rst_ni && (head_is_err || timeout || (head_rv && |(dev_err_i & head_oh)));
    assign dev_sel_o = rst_ni ? head_oh : '0;
    assign pop       = rvalid_o;

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < int'(NUM_DEV); i++) begin
            if (rst_ni && head_rv && head_oh[i]) begin
                rdata_o = dev_rdata_i[i];
            end
        end
    end

    bus_addr_demux_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (push),
        .push_id (target),
        .pop     (pop),
        .head_id (head_id),
        .tail_id (tail_id),
        .count   (count)
    );

`ifndef SYNTHESIS
    a_timeout_cfg : assert property (@(posedge clk_i) TIMEOUT_CYCLES > 1);

    a_host_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> (req_i && $stable({we_i, be_i, addr_i, wdata_i})));

    a_rvalid_owner : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (nonempty && !head_is_err) |-> ((dev_rv & ~head_oh) == '0));
`endif

endmodule

// File: doc/bus_addr_demux.md
Name: bus_addr_demux

Overview:
- Request-side counterpart of the read-data mux: fans one host request port (Ibex LSU-style req/gnt/rvalid protocol) out to NUM_DEV device ports by address decode.
- Tracks outstanding transactions in order, so it can:
  - steer the device's rvalid/rdata/err back to the host;
  - drive a one-hot response selector (dev_sel_o) usable by the response mux.
- Unmapped addresses are granted locally and answered with an error response.

Parameters:
- NUM_DEV, 2, number of device ports (1..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8.
- MAX_OUTSTANDING, 2, depth of the in-order response-tracking FIFO (1..8).
- DEV_BASE, {NUM_DEV}x ADDR_WIDTH, base address per device.
- DEV_MASK, {NUM_DEV}x ADDR_WIDTH, decode mask per device.
- TIMEOUT_CYCLES, 1024, response watchdog limit (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  host request
- gnt_o  out  1  host grant
- we_i  in  1  write enable
- be_i  in  DATA_WIDTH/8  byte enables
- addr_i  in  ADDR_WIDTH  address
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid
- rdata_o  out  DATA_WIDTH  response data
- err_o  out  1  response error
- dev_req_o  out  NUM_DEV  per-device request
- dev_gnt_i  in  NUM_DEV  per-device grant
- dev_addr_o / dev_we_o / dev_be_o / dev_wdata_o  out  shared  broadcast copies of the host signals
- dev_rvalid_i  in  NUM_DEV  per-device response valid
- dev_rdata_i  in  NUM_DEV x DATA_WIDTH  per-device read data
- dev_err_i  in  NUM_DEV  per-device error
- dev_sel_o  out  NUM_DEV  one-hot owner of the FIFO head entry; 0 when the FIFO is empty or the head is an error entry

Behaviour:
- Decode
  - Device i hits when (addr_i & DEV_MASK[i]) == DEV_BASE[i].
  - Lowest index wins on overlap.
  - No hit: target = ERR (id NUM_DEV).
- Issue condition
  - Condition: req_i && count < MAX_OUTSTANDING && (count == 0 || target == tail_id).
  - A switch of target device waits for the FIFO to drain. This keeps responses in order.
- Forwarding and grant
  - dev_req_o[target] = req_i && issue condition. Combinational, zero latency.
  - gnt_o = dev_gnt_i[target] for device targets; 1 for ERR.
- FIFO
  - Push: on the host handshake, push the target id.
  - Pop: when rvalid_o is asserted.
  - Simultaneous push and pop is legal, including at count == MAX_OUTSTANDING-1. Count is unchanged.
  - A push when full never occurs, because gnt is blocked while full.
- Response path, head = device d
  - rvalid_o = dev_rvalid_i[d], rdata_o = dev_rdata_i[d], err_o = dev_err_i[d]. All combinational.
  - dev_rvalid_i from non-head devices is ignored (protocol violation; assertion).
- Response path, head = ERR
  - rvalid_o = 1 and err_o = 1 for exactly one cycle, at the earliest the cycle after grant.
  - rdata_o = 0.
- Reset and state outputs
  - On reset: count = 0 and pointers = 0.
  - While rst_ni is low: gnt_o, dev_req_o, rvalid_o, err_o = 0; rdata_o = 0; dev_sel_o = 0.
  - Reset mid-transaction discards all outstanding entries. Devices are reset by the same rst_ni.
- The host must hold request signals stable until gnt_o (assertion).

Optional Feature:
- BUS_ADDR_DEMUX_TIMEOUT_EN defined:
  - A watchdog counts cycles while the FIFO is non-empty and the head has had no rvalid.
  - At TIMEOUT_CYCLES: one-cycle rvalid_o = 1, err_o = 1, rdata_o = 0, and the head is popped.
  - That device's per-device drop counter is incremented. Its next dev_rvalid_i is swallowed and the counter decremented.
  - The watchdog restarts on every pop.
- Undefined: no watchdog and no drop counters; a missing response stalls the block indefinitely.

Decomposition:
- Package bus_addr_demux_pkg holds:
  - dev_id_t (clog2(NUM_DEV+1) bits);
  - ERR_ID constant;
  - default DEV_BASE/DEV_MASK constants;
  - the watchdog counter width.
- One sub-module, bus_addr_demux_fifo: in-order id FIFO with push/pop/count/head/tail outputs.

Test Plan:
- Read to 0x0000_0010 with DEV_BASE[0]=0x0, DEV_MASK[0]=0xFFFF_0000:
  - dev_req_o=01, gnt on dev_gnt_i[0].
  - Device 0 returns 0xDEAD_BEEF two cycles later -> rvalid_o=1, rdata_o=0xDEAD_BEEF, dev_sel_o=01.
- Unmapped address 0x9000_0000 -> gnt_o=1 the same cycle; next cycle rvalid_o=1, err_o=1, rdata_o=0.
- Two back-to-back requests to device 1 with MAX_OUTSTANDING=2 -> both granted; a third request is held (gnt_o=0) until the first response pops.
- Device 0 request outstanding, then host requests device 1 -> dev_req_o[1]=0 until the device 0 rvalid arrives; issued the following cycle.
- rst_ni pulled low with 2 outstanding -> count=0; rvalid_o=0; a later spurious dev_rvalid_i is ignored.
- With BUS_ADDR_DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES=16, device 0 silent:
  - Cycle 16 -> err response.
  - Late device 0 rvalid swallowed; the next transaction is returned correctly.
